// File: rtl/mdu_pkg.sv
// Shared MDU definitions: SPECIAL-opcode funct codes, op enumeration and the
// instruction decoder that both the EX-stage MDU and the ID hazard unit use.
package mdu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] F_MFHI     = 6'h10;
    localparam logic [5:0] F_MTHI     = 6'h11;
    localparam logic [5:0] F_MFLO     = 6'h12;
    localparam logic [5:0] F_MTLO     = 6'h13;
    localparam logic [5:0] F_MULT     = 6'h18;
    localparam logic [5:0] F_MULTU    = 6'h19;
    localparam logic [5:0] F_DIV      = 6'h1A;
    localparam logic [5:0] F_DIVU     = 6'h1B;

    typedef enum logic [3:0] {
        MDU_NONE,
        MDU_MULT,
        MDU_MULTU,
        MDU_DIV,
        MDU_DIVU,
        MDU_MTHI,
        MDU_MTLO,
        MDU_MFHI,
        MDU_MFLO
    } mdu_op_e;

    // Only opcode and funct matter; a bubble (all zeros) decodes as SLL -> NONE.
    function automatic mdu_op_e mdu_decode(input logic [31:0] instr);
        mdu_op_e op;
        op = MDU_NONE;
        if (instr[31:26] == OP_SPECIAL) begin
            case (instr[5:0])
                F_MFHI:  op = MDU_MFHI;
                F_MTHI:  op = MDU_MTHI;
                F_MFLO:  op = MDU_MFLO;
                F_MTLO:  op = MDU_MTLO;
                F_MULT:  op = MDU_MULT;
                F_MULTU: op = MDU_MULTU;
                F_DIV:   op = MDU_DIV;
                F_DIVU:  op = MDU_DIVU;
                default: op = MDU_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// EX-stage MDU port bundle: instruction/operands in, stall and HI/LO results out.
interface ex_mdu_if;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output instr, rs_val, rt_val,
        input  start, busy, md_stall, hi, lo, md_out
    );

    modport slave (
        input  instr, rs_val, rt_val,
        output start, busy, md_stall, hi, lo, md_out
    );
endinterface

// File: rtl/ex_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. The result is computed at
// issue and held in pending registers until the fixed latency expires.
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    ex_mdu_if.slave     mdu
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e        r_state;
    logic          r_busy;
    logic [CW-1:0] r_count;
    logic [31:0]   r_hi, r_lo;
    logic [31:0]   r_pend_hi, r_pend_lo;
    logic          r_pend_wr;

    mdu_op_e       w_op;
    logic          w_is_mul, w_is_div, w_start;
    logic [63:0]   w_prod;
    logic          w_sdiv, w_qneg, w_rneg, w_divz;
    logic [31:0]   w_dvd, w_dvs, w_dvs_safe, w_quo, w_rem;
    logic [31:0]   w_res_hi, w_res_lo, w_md_out;

    always_comb begin
        w_op     = mdu_decode(mdu.instr);
        w_is_mul = (w_op == MDU_MULT) || (w_op == MDU_MULTU);
        w_is_div = (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
        w_start  = (w_is_mul || w_is_div) && (r_state == S_IDLE);
    end

    // Low 64 bits of the product of extended operands equal the signed product.
    always_comb begin
        if (w_op == MDU_MULT)
            w_prod = {{32{mdu.rs_val[31]}}, mdu.rs_val} * {{32{mdu.rt_val[31]}}, mdu.rt_val};
        else
            w_prod = {32'b0, mdu.rs_val} * {32'b0, mdu.rt_val};
    end

    // Signed divide via magnitudes: truncation toward zero, remainder follows
    // the dividend, and 0x80000000/-1 wraps naturally to 0x80000000 rem 0.
    always_comb begin
        w_sdiv     = (w_op == MDU_DIV);
        w_dvd      = (w_sdiv && mdu.rs_val[31]) ? -mdu.rs_val : mdu.rs_val;
        w_dvs      = (w_sdiv && mdu.rt_val[31]) ? -mdu.rt_val : mdu.rt_val;
        w_divz     = (mdu.rt_val == 32'b0);
        w_dvs_safe = w_divz ? 32'd1 : w_dvs;
        w_quo      = w_dvd / w_dvs_safe;
        w_rem      = w_dvd % w_dvs_safe;
        w_qneg     = w_sdiv && (mdu.rs_val[31] ^ mdu.rt_val[31]);
        w_rneg     = w_sdiv && mdu.rs_val[31];
        if (w_is_div) begin
            w_res_lo = w_qneg ? -w_quo : w_quo;
            w_res_hi = w_rneg ? -w_rem : w_rem;
        end else begin
            w_res_lo = w_prod[31:0];
            w_res_hi = w_prod[63:32];
        end
    end

    always_comb begin
        w_md_out = 32'b0;
        if (w_op == MDU_MFHI) w_md_out = r_hi;
        else if (w_op == MDU_MFLO) w_md_out = r_lo;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_hi      <= 32'b0;
            r_lo      <= 32'b0;
            r_pend_hi <= 32'b0;
            r_pend_lo <= 32'b0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_pend_wr <= !(w_is_div && w_divz);
                        r_count   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else if (w_op == MDU_MTHI) begin
                        r_hi <= mdu.rs_val;
                    end else if (w_op == MDU_MTLO) begin
                        r_lo <= mdu.rs_val;
                    end
                end
                S_RUN: begin
                    // New issues and MT writes are ignored while in flight.
                    if (r_count == CW'(1)) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu.start    = w_start;
    assign mdu.busy     = r_busy;
    assign mdu.md_stall = w_start | r_busy;
    assign mdu.hi       = r_hi;
    assign mdu.lo       = r_lo;
    assign mdu.md_out   = w_md_out;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed-vector bench for ex_mdu: latency, HI/LO results, divide-by-zero,
// mid-operation reset and MTHI/MFHI forwarding.
module tb_ex_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ex_mdu_if mdu_if ();

    ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] funct);
        return {OP_SPECIAL, 5'd1, 5'd2, 10'd0, funct};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        mdu_if.instr  = ins;
        mdu_if.rs_val = rs;
        mdu_if.rt_val = rt;
    endtask

    // Issue in the current cycle, walk the busy window, end in the first idle cycle.
    task automatic run_op(input string tag, input logic [5:0] funct,
                          input logic [31:0] rs, input logic [31:0] rt, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cnt;
        drive(mk(funct), rs, rt);
        #1;
        chk({tag, ".start"}, {31'b0, mdu_if.start}, 32'd1);
        chk({tag, ".stall0"}, {31'b0, mdu_if.md_stall}, 32'd1);
        step();
        drive(32'h0, 32'h0, 32'h0);
        #1;
        busy_cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (mdu_if.busy && mdu_if.md_stall && !mdu_if.start) busy_cnt++;
            step();
        end
        chk({tag, ".busycyc"}, busy_cnt, n);
        chk({tag, ".idle"}, {31'b0, mdu_if.busy}, 32'd0);
        chk({tag, ".hi"}, mdu_if.hi, exp_hi);
        chk({tag, ".lo"}, mdu_if.lo, exp_lo);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0);
        step();
        step();
        chk("rst.hi", mdu_if.hi, 32'h0);
        chk("rst.lo", mdu_if.lo, 32'h0);
        chk("rst.busy", {31'b0, mdu_if.busy}, 32'd0);
        chk("rst.stall", {31'b0, mdu_if.md_stall}, 32'd0);
        reset = 1'b1;
        drive(mk(F_MFLO), 32'h0, 32'h0);
        #1;
        chk("mflo.rst", mdu_if.md_out, 32'h0);
        step();

        run_op("mult", F_MULT, 32'hFFFFFFFF, 32'h2, MC, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'h2, MC, 32'h00000001, 32'hFFFFFFFE);
        // Back-to-back: issues in the first idle cycle left by MULTU.
        run_op("divu", F_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14);
        run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000);
        run_op("div_nd", F_DIV, 32'd7, 32'hFFFFFFFE, DC, 32'd1, 32'hFFFFFFFD);

        drive(mk(F_MTHI), 32'h11, 32'h0);
        step();
        drive(mk(F_MTLO), 32'h22, 32'h0);
        step();
        run_op("divz", F_DIVU, 32'd7, 32'd0, DC, 32'h11, 32'h22);

        // Reset lands at the end of the third busy cycle.
        drive(mk(F_MULT), 32'd3, 32'd4);
        step();
        drive(32'h0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst.busy", {31'b0, mdu_if.busy}, 32'd0);
        chk("mrst.hi", mdu_if.hi, 32'h0);
        chk("mrst.lo", mdu_if.lo, 32'h0);
        repeat (MC + 2) step();
        chk("mrst.hi_late", mdu_if.hi, 32'h0);
        chk("mrst.lo_late", mdu_if.lo, 32'h0);

        drive(mk(F_MTHI), 32'hDEADBEEF, 32'h0);
        #1;
        chk("mthi.stall", {31'b0, mdu_if.md_stall}, 32'd0);
        step();
        drive(mk(F_MFHI), 32'h0, 32'h0);
        #1;
        chk("mfhi", mdu_if.md_out, 32'hDEADBEEF);
        chk("mfhi.busy", {31'b0, mdu_if.busy}, 32'd0);
        drive(mk(F_MFLO), 32'h0, 32'h0);
        #1;
        chk("mflo", mdu_if.md_out, 32'h0);
        drive(32'h0, 32'h0, 32'h0);
        #1;
        chk("bubble.out", mdu_if.md_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
